// File: rtl/tiny_cpu_sequencer_if.sv
// Host-side bus of the TinyCPU program sequencer: memory load port, run
// control, the CPU Result feedback and the sequencer outputs.
// Optional macro SEQ_SINGLE_STEP_EN adds the step_mode/step controls.
interface tiny_cpu_sequencer_if #(
  parameter int AW = 4
) ();
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [11:0]   load_data;
  logic          start;
  logic [AW:0]   length;
  logic          abort;
  logic [7:0]    result;
  logic [11:0]   instr;
  logic          busy;
  logic          done;
  logic [AW-1:0] pc;
  logic [7:0]    final_result;
`ifdef SEQ_SINGLE_STEP_EN
  logic          step_mode;
  logic          step;
`endif

  modport master (
`ifdef SEQ_SINGLE_STEP_EN
    output step_mode, step,
`endif
    output load_en, load_addr, load_data, start, length, abort, result,
    input  instr, busy, done, pc, final_result
  );

  modport slave (
`ifdef SEQ_SINGLE_STEP_EN
    input  step_mode, step,
`endif
    input  load_en, load_addr, load_data, start, length, abort, result,
    output instr, busy, done, pc, final_result
  );
endinterface

// File: rtl/tiny_cpu_sequencer.sv
// TinyCPU program sequencer. Holds a 2**AW-word instruction memory loaded
// while idle, then plays the words onto instr for HOLD_CYCLES clocks each,
// stopping at the run length, on a HALT word (opcode 4'hF) or on abort.
// On a normal or HALT stop the CPU result is captured and done pulses.
// Optional macro SEQ_SINGLE_STEP_EN adds a PAUSE state after every word,
// released by a step pulse when step_mode is set.
module tiny_cpu_sequencer #(
  parameter int          AW          = 4,
  parameter int          HOLD_CYCLES = 4,
  parameter logic [11:0] IDLE_WORD   = 12'hF00
) (
  input logic                 clk,
  input logic                 rst,
  tiny_cpu_sequencer_if.slave bus
);
  localparam int            DEPTH     = 1 << AW;
  localparam int            HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [AW:0]   MAX_LEN   = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   IDX_ONE   = (AW + 1)'(1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [3:0]    HALT_OP   = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
`ifdef SEQ_SINGLE_STEP_EN
    PAUSE,
`endif
    DONE
  } state_t;

  state_t        state, state_next;
  logic [11:0]   mem [DEPTH];
  logic [AW:0]   idx, idx_next;
  logic [AW:0]   len, len_next;
  logic [HW-1:0] hold, hold_next;
  logic [11:0]   instr, instr_next;
  logic [7:0]    final_result, final_next;
  logic [AW:0]   len_clamp;
  logic [AW:0]   cand;
  logic [11:0]   first_word;
  logic [11:0]   cand_word;
  logic          cand_ends;

  // Instruction memory: written only while idle, never cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst && state == IDLE && bus.load_en)
      mem[bus.load_addr] <= bus.load_data;
  end

  // Candidate word lookup: the word that would issue next and whether the run stops there.
  always_comb begin
    len_clamp  = (bus.length > MAX_LEN) ? MAX_LEN : bus.length;
    first_word = (bus.load_en && bus.load_addr == '0) ? bus.load_data : mem[0];
`ifdef SEQ_SINGLE_STEP_EN
    cand = (state == PAUSE) ? idx : idx + IDX_ONE;
`else
    cand = idx + IDX_ONE;
`endif
    cand_word = mem[cand[AW-1:0]];
    cand_ends = (cand == len) || (cand_word[11:8] == HALT_OP);
  end

  // Next-state and datapath updates for the run sequence.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    len_next   = len;
    hold_next  = hold;
    instr_next = instr;
    final_next = final_result;
    case (state)
      IDLE: begin
        if (bus.start) begin
          len_next  = len_clamp;
          idx_next  = '0;
          hold_next = '0;
          if (len_clamp == '0 || first_word[11:8] == HALT_OP) begin
            state_next = DONE;
            final_next = bus.result;
            instr_next = IDLE_WORD;
          end else begin
            state_next = RUN;
            instr_next = first_word;
          end
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_next = IDLE;
          instr_next = IDLE_WORD;
          idx_next   = '0;
          hold_next  = '0;
        end else if (hold == HOLD_LAST) begin
          hold_next = '0;
`ifdef SEQ_SINGLE_STEP_EN
          if (bus.step_mode) begin
            state_next = PAUSE;
            instr_next = IDLE_WORD;
            idx_next   = cand;
          end else
`endif
          if (cand_ends) begin
            state_next = DONE;
            final_next = bus.result;
            instr_next = IDLE_WORD;
            idx_next   = '0;
          end else begin
            idx_next   = cand;
            instr_next = cand_word;
          end
        end else begin
          hold_next = hold + HOLD_ONE;
        end
      end
`ifdef SEQ_SINGLE_STEP_EN
      PAUSE: begin
        if (bus.abort) begin
          state_next = IDLE;
          idx_next   = '0;
        end else if (bus.step) begin
          if (cand_ends) begin
            state_next = DONE;
            final_next = bus.result;
            idx_next   = '0;
          end else begin
            state_next = RUN;
            instr_next = cand_word;
          end
        end
      end
`endif
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        instr_next = IDLE_WORD;
        idx_next   = '0;
        hold_next  = '0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      len          <= '0;
      hold         <= '0;
      instr        <= IDLE_WORD;
      final_result <= 8'h00;
    end else begin
      state        <= state_next;
      idx          <= idx_next;
      len          <= len_next;
      hold         <= hold_next;
      instr        <= instr_next;
      final_result <= final_next;
    end
  end

  assign bus.instr        = instr;
`ifdef SEQ_SINGLE_STEP_EN
  assign bus.busy         = (state == RUN) || (state == PAUSE);
`else
  assign bus.busy         = (state == RUN);
`endif
  assign bus.done         = (state == DONE);
  assign bus.pc           = idx[AW] ? {AW{1'b1}} : idx[AW-1:0];
  assign bus.final_result = final_result;
endmodule

// File: tb/tb_tiny_cpu_sequencer.sv
// Self-checking bench for tiny_cpu_sequencer: directed scenarios with
// hand-computed expectations, then randomized traffic, all checked every
// cycle against a timeline model of the run (index = elapsed cycles / H).
module tb_tiny_cpu_sequencer;
  localparam int          AW        = 4;
  localparam int          H         = 4;
  localparam int          DEPTH     = 1 << AW;
  localparam logic [11:0] IDLE_WORD = 12'hF00;
  localparam int          M_IDLE    = 0;
  localparam int          M_RUN     = 1;
  localparam int          M_DONE    = 2;

  logic clk = 1'b0;
  logic rst;

  tiny_cpu_sequencer_if #(.AW(AW)) bus ();

  tiny_cpu_sequencer #(
    .AW(AW),
    .HOLD_CYCLES(H),
    .IDLE_WORD(IDLE_WORD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [11:0] mmem [DEPTH];
  int          mmode = M_IDLE;
  int          mk = 0;
  int          mn = 0;
  logic [7:0]  mfinal = 8'h00;
  int          edgeNum = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edgeNum);
    end
  endtask

  task automatic modelStep();
    int l;
    edgeNum++;
    if (rst) begin
      mmode  = M_IDLE;
      mfinal = 8'h00;
    end else begin
      case (mmode)
        M_IDLE: begin
          if (bus.load_en) mmem[bus.load_addr] = bus.load_data;
          if (bus.start) begin
            l  = (int'(bus.length) > DEPTH) ? DEPTH : int'(bus.length);
            mn = l;
            for (int i = 0; i < l; i++) begin
              if (mmem[i][11:8] == 4'hF) begin
                mn = i;
                break;
              end
            end
            mk = edgeNum;
            if (mn == 0) begin
              mmode  = M_DONE;
              mfinal = bus.result;
            end else begin
              mmode = M_RUN;
            end
          end
        end
        M_RUN: begin
          if (bus.abort) begin
            mmode = M_IDLE;
          end else if (edgeNum - mk == mn * H) begin
            mmode  = M_DONE;
            mfinal = bus.result;
          end
        end
        default: mmode = M_IDLE;
      endcase
    end
  endtask

  task automatic checkOutput();
    int          word;
    logic [11:0] eInstr;
    word   = (edgeNum - mk) / H;
    eInstr = (mmode == M_RUN) ? mmem[word] : IDLE_WORD;
    cmp("instr", bus.instr, eInstr);
    cmp("busy", bus.busy, mmode == M_RUN);
    cmp("done", bus.done, mmode == M_DONE);
    cmp("final_result", bus.final_result, mfinal);
    if (mmode == M_RUN) cmp("pc", bus.pc, word);
  endtask

  task automatic applyStimulus();
    modelStep();
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic loadWord(input int addr, input logic [11:0] data);
    bus.load_en   = 1'b1;
    bus.load_addr = AW'(addr);
    bus.load_data = data;
    applyStimulus();
    bus.load_en = 1'b0;
  endtask

  task automatic startRun(input int len);
    bus.start  = 1'b1;
    bus.length = (AW + 1)'(len);
    applyStimulus();
    bus.start = 1'b0;
  endtask

  logic [11:0] prog [8];
  int          doneCount;

  initial begin
    prog[0] = 12'h000; prog[1] = 12'h107; prog[2] = 12'h208; prog[3] = 12'h400;
    prog[4] = 12'h900; prog[5] = 12'hB00; prog[6] = 12'h600; prog[7] = 12'h300;
    for (int i = 0; i < DEPTH; i++) mmem[i] = 12'h000;
`ifdef SEQ_SINGLE_STEP_EN
    bus.step_mode = 1'b0;
    bus.step      = 1'b0;
`endif
    rst           = 1'b1;
    bus.load_en   = 1'b0;
    bus.load_addr = '0;
    bus.load_data = 12'h000;
    bus.start     = 1'b0;
    bus.length    = '0;
    bus.abort     = 1'b0;
    bus.result    = 8'h00;

    applyStimulus();
    applyStimulus();
    cmp("reset_instr", bus.instr, 12'hF00);
    cmp("reset_busy", bus.busy, 0);
    cmp("reset_done", bus.done, 0);
    cmp("reset_pc", bus.pc, 0);
    cmp("reset_final", bus.final_result, 8'h00);
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++)
      loadWord(i, (i < 8) ? prog[i] : {4'(i % 15), 8'(i * 7)});

    bus.result = 8'h03;
    startRun(8);
    for (int j = 0; j <= 33; j++) begin
      if (j >= 4 && j <= 7) cmp("prog_instr1", bus.instr, 12'h107);
      if (j == 31) cmp("prog_busy_last", bus.busy, 1);
      if (j == 32) begin
        cmp("prog_done", bus.done, 1);
        cmp("prog_busy_end", bus.busy, 0);
        cmp("prog_final", bus.final_result, 8'h03);
      end
      applyStimulus();
    end

    loadWord(3, 12'hF00);
    bus.result = 8'h00;
    startRun(8);
    for (int j = 0; j <= 14; j++) begin
      if (j >= 8 && j <= 11) cmp("halt_instr2", bus.instr, 12'h208);
      if (j == 12) begin
        cmp("halt_done", bus.done, 1);
        cmp("halt_instr", bus.instr, 12'hF00);
        cmp("halt_final", bus.final_result, 8'h00);
      end
      applyStimulus();
    end

    loadWord(3, 12'h400);
    bus.result = 8'h5A;
    startRun(8);
    for (int j = 0; j <= 14; j++) begin
      bus.load_en = (j == 2);
      bus.load_addr = 4'd1;
      bus.load_data = 12'h555;
      bus.abort = (j == 9);
      if (j >= 10) begin
        cmp("abort_busy", bus.busy, 0);
        cmp("abort_instr", bus.instr, 12'hF00);
        cmp("abort_done", bus.done, 0);
        cmp("abort_final", bus.final_result, 8'h00);
      end
      applyStimulus();
    end
    bus.load_en = 1'b0;
    bus.abort   = 1'b0;
    bus.result  = 8'h77;
    startRun(2);
    for (int j = 0; j <= 9; j++) begin
      if (j >= 4 && j <= 7) cmp("reread_instr1", bus.instr, 12'h107);
      if (j == 8) cmp("reread_final", bus.final_result, 8'h77);
      applyStimulus();
    end

    bus.result = 8'h21;
    startRun(0);
    cmp("len0_done", bus.done, 1);
    cmp("len0_busy", bus.busy, 0);
    cmp("len0_instr", bus.instr, 12'hF00);
    applyStimulus();
    doneCount = 0;
    startRun(2);
    for (int j = 0; j <= 12; j++) begin
      if (bus.done) doneCount++;
      if (j == 8) cmp("busystart_done", bus.done, 1);
      bus.start  = (j == 3);
      bus.length = 5'd1;
      applyStimulus();
    end
    bus.start = 1'b0;
    cmp("busystart_done_count", doneCount, 1);

    bus.load_en   = 1'b1;
    bus.load_addr = '0;
    bus.load_data = 12'h1AB;
    startRun(1);
    bus.load_en = 1'b0;
    cmp("loadstart_instr", bus.instr, 12'h1AB);
    for (int j = 0; j <= 5; j++) applyStimulus();

    startRun(31);
    for (int j = 0; j <= 65; j++) begin
      if (j == 62) cmp("clamp_pc", bus.pc, 15);
      if (j == 64) cmp("clamp_done", bus.done, 1);
      applyStimulus();
    end

    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom_range(0, 299) == 0);
      bus.load_en   = ($urandom_range(0, 2) == 0);
      bus.load_addr = AW'($urandom_range(0, DEPTH - 1));
      bus.load_data = ($urandom_range(0, 9) == 0) ? {4'hF, 8'($urandom)}
                                                  : {4'($urandom_range(0, 14)), 8'($urandom)};
      bus.start     = ($urandom_range(0, 19) == 0);
      bus.length    = (AW + 1)'($urandom_range(0, 20));
      bus.abort     = ($urandom_range(0, 49) == 0);
      bus.result    = 8'($urandom);
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
